// File: rtl/alu_pkg.sv
// Shared ALU control codes and the execute-stage FSM encoding.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative shift-add multiplier: one multiplier bit per step, fixed WIDTH steps.
module mul_shift_add #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt_q;

  always_comb begin
    acc_next = acc_q;
    if (mplier_q[0]) acc_next = acc_q + mcand_q;
  end

  // The product is the accumulator after the step taken on the done cycle.
  assign product_o = acc_next;
  assign done_o    = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arith ops, iterative MUL with busy stall.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             valid_o,
  output logic             busy_o
);

  alu_state_e       state_q, state_d;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] alu_res;
  logic             mul_start, mul_clear, mul_step, mul_done;
  logic [WIDTH-1:0] mul_product;

  mul_shift_add #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start),
    .clear_i   (mul_clear),
    .step_i    (mul_step),
    .mcand_i   (data1_i),
    .mplier_i  (data2_i),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      ALU_AND: alu_res = data1_i & data2_i;
      ALU_OR:  alu_res = data1_i | data2_i;
      ALU_ADD: alu_res = data1_i + data2_i;
      ALU_SUB: alu_res = data1_i - data2_i;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_val  = '0;
    mul_start = 1'b0;
    mul_clear = 1'b0;
    mul_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          mul_clear = 1'b1;
        end else if (valid_i) begin
          if (ALUCtrl_i == ALU_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            load     = 1'b1;
            load_val = alu_res;
          end
        end
      end
      ST_MUL: begin
        // Flush wins even on the final step, so the product is never loaded.
        if (flush_i) begin
          mul_clear = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          mul_step = 1'b1;
          if (mul_done) begin
            load     = 1'b1;
            load_val = mul_product;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      data_o  <= '0;
      zero_o  <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_o <= load;
      if (load) begin
        data_o <= load_val;
        zero_o <= (load_val == '0);
      end
    end
  end

  assign busy_o = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized and directed checks of alu_multicycle against an arithmetic reference model.
module tb_alu_multicycle;

  localparam int unsigned W = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          valid_i = 1'b0;
  logic [2:0]    ALUCtrl_i = 3'b000;
  logic [W-1:0]  data1_i = '0;
  logic [W-1:0]  data2_i = '0;
  logic          flush_i = 1'b0;
  logic [W-1:0]  data_o;
  logic          zero_o;
  logic          valid_o;
  logic          busy_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [W-1:0] exp_data = '0;

  alu_multicycle #(
    .WIDTH(W)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .flush_i   (flush_i),
    .data_o    (data_o),
    .zero_o    (zero_o),
    .valid_o   (valid_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd3: return a - b;
      3'd7: begin p = 64'(a) * 64'(b); return p[W-1:0]; end
      default: return '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic fl);
    valid_i = v; ALUCtrl_i = op; data1_i = a; data2_i = b; flush_i = fl;
  endtask

  // Issue a single-cycle op; leaves valid_i low afterwards.
  task automatic run_single(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    drive(1'b1, op, a, b, 1'b0);
    tick();
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    exp_data = model(op, a, b);
    check("single_valid", W'(valid_o), W'(1));
    check("single_data", data_o, exp_data);
    check("single_zero", W'(zero_o), W'(exp_data == '0));
    check("single_busy", W'(busy_o), W'(0));
  endtask

  task automatic idle_cycle();
    tick();
    check("idle_valid", W'(valid_o), W'(0));
    check("idle_data", data_o, exp_data);
  endtask

  // MUL with optional stray request at cycle interfere_at and flush at cycle flush_at (0 = none).
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int interfere_at, input int flush_at, input bit flush_with_valid);
    drive(1'b1, 3'd7, a, b, 1'b0);
    tick();
    for (int k = 1; k <= int'(W); k++) begin
      check("mul_busy", W'(busy_o), W'(1));
      check("mul_novalid", W'(valid_o), W'(0));
      check("mul_hold", data_o, exp_data);
      if (k == flush_at) begin
        drive(flush_with_valid, 3'd2, 32'd1, 32'd1, 1'b1);
        tick();
        drive(1'b0, 3'd0, '0, '0, 1'b0);
        check("flush_busy", W'(busy_o), W'(0));
        check("flush_valid", W'(valid_o), W'(0));
        check("flush_data", data_o, exp_data);
        idle_cycle();
        check("flush_busy2", W'(busy_o), W'(0));
        return;
      end
      if (k == interfere_at) drive(1'b1, 3'd2, 32'd1, 32'd1, 1'b0);
      else drive(1'b0, 3'd0, '0, '0, 1'b0);
      tick();
    end
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    exp_data = model(3'd7, a, b);
    check("mul_valid", W'(valid_o), W'(1));
    check("mul_busy_done", W'(busy_o), W'(0));
    check("mul_data", data_o, exp_data);
    check("mul_zero", W'(zero_o), W'(exp_data == '0));
  endtask

  initial begin
    logic [2:0] op;
    logic [W-1:0] a, b;
    #12 rst_i = 1'b0;
    #1;
    check("rst_data", data_o, '0);
    check("rst_zero", W'(zero_o), W'(1));
    check("rst_valid", W'(valid_o), W'(0));
    check("rst_busy", W'(busy_o), W'(0));

    tick();
    run_single(3'd2, 32'd5, 32'd3);
    idle_cycle();
    check("add_busy_after", W'(busy_o), W'(0));

    run_single(3'd3, 32'd5, 32'd7);
    run_single(3'd0, 32'hF0F0F0F0, 32'h0F0F0F0F);
    idle_cycle();

    run_single(3'd5, 32'h1234, 32'h5678);
    idle_cycle();

    // Flush and request together in IDLE: request dropped.
    run_single(3'd2, 32'd9, 32'd9);
    drive(1'b1, 3'd2, 32'd100, 32'd1, 1'b1);
    tick();
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    check("idle_flush_valid", W'(valid_o), W'(0));
    check("idle_flush_data", data_o, exp_data);

    run_mul(32'd7, 32'd6, 10, 0, 1'b0);
    run_mul(32'hFFFFFFFF, 32'd2, 0, 0, 1'b0);
    run_mul(32'h1234_5678, 32'd0, 0, 0, 1'b0);
    run_single(3'd1, 32'h0000_0F00, 32'h0000_00F0);
    run_mul(32'd3, 32'd3, 0, 20, 1'b0);
    run_mul(32'd3, 32'd3, 0, 20, 1'b1);
    run_mul(32'd11, 32'd13, 0, int'(W), 1'b0);
    // Back-to-back after MUL completion.
    run_mul(32'd9, 32'd9, 0, 0, 1'b0);
    run_single(3'd2, 32'd40, 32'd2);
    idle_cycle();

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom();
      b = $urandom();
      if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
      if (op == 3'd7) run_mul(a, b, 0, ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, W)) : 0, 1'b0);
      else run_single(op, a, b);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    // Asynchronous reset right after a result pulse.
    run_single(3'd2, 32'd21, 32'd21);
    #3 rst_i = 1'b1;
    #1;
    check("arst_valid", W'(valid_o), W'(0));
    check("arst_data", data_o, '0);
    check("arst_zero", W'(zero_o), W'(1));
    #2 rst_i = 1'b0;
    exp_data = '0;

    // Asynchronous reset in the middle of a MUL.
    drive(1'b1, 3'd7, 32'd7, 32'd6, 1'b0);
    tick();
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    check("pre_arst_busy", W'(busy_o), W'(1));
    #3 rst_i = 1'b1;
    #1;
    check("arst_mul_busy", W'(busy_o), W'(0));
    check("arst_mul_data", data_o, '0);
    check("arst_mul_zero", W'(zero_o), W'(1));
    check("arst_mul_valid", W'(valid_o), W'(0));
    #2 rst_i = 1'b0;
    for (int k = 0; k < int'(W) + 2; k++) begin
      tick();
      check("arst_no_late_valid", W'(valid_o), W'(0));
    end
    run_single(3'd2, 32'd2, 32'd2);
    check("post_rst_add", data_o, 32'd4);
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
